// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared XALUOp encodings, default cycle counts and FSM states
//   for the multiply/divide unit, its decoder and the stall unit.
// Contents: muldiv_op_e (4-bit op code), muldiv_state_e, *_CYCLES_DEF.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } muldiv_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } muldiv_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Ops that put the unit into BUSY (madd family only when enabled).
  function automatic logic is_launch_op(input logic [3:0] op, input logic madd_en);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU:    r = 1'b1;
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:  r = madd_en;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: MIPS-style HI/LO multiply/divide unit with fixed-latency Busy.
// Ports: clk, reset (sync, active-high); A/B/XALUOp/Start/IntReq from E stage;
//   Busy/StallX to stall unit; HI/LO architectural regs; Out = mfhi/mflo read.
// Result is computed at launch and held in pHI/pLO; it is committed to HI/LO on
//   the edge the down-counter expires, so Busy is purely a timing model.
// Optional: define MULDIV_MADD_EN to enable madd/maddu/msub/msubu (ops 9-12).
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  XALUOp,
  input  logic        Start,
  input  logic        IntReq,
  output logic        Busy,
  output logic        StallX,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

`ifdef MULDIV_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      phi_q, phi_d, plo_q, plo_d;

  logic        launch;
  logic        use_div;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic [31:0] res_hi, res_lo;

  // Datapath: everything is evaluated on the launch operands.
  always_comb begin
    // Low 64 bits of the product of sign/zero-extended operands.
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    // SV signed / and % truncate toward zero; remainder takes A's sign.
    quot_s = $signed(A) / $signed(B);
    rem_s  = $signed(A) % $signed(B);
    quot_u = A / B;
    rem_u  = A % B;
  end

  always_comb begin
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    use_div = 1'b0;
    case (XALUOp)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        use_div = 1'b1;
        if (B == 32'd0) {res_hi, res_lo} = {A, 32'hFFFF_FFFF};
        else            {res_hi, res_lo} = {rem_s, quot_s};
      end
      OP_DIVU: begin
        use_div = 1'b1;
        if (B == 32'd0) {res_hi, res_lo} = {A, 32'hFFFF_FFFF};
        else            {res_hi, res_lo} = {rem_u, quot_u};
      end
`ifdef MULDIV_MADD_EN
      // Accumulate against the architectural HI/LO at launch, mod 2^64.
      OP_MADD:  {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
      OP_MADDU: {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
      OP_MSUB:  {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
      OP_MSUBU: {res_hi, res_lo} = {hi_q, lo_q} - prod_u;
`endif
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  // FSM next-state and register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    launch  = (state_q == ST_IDLE) && Start && !IntReq && is_launch_op(XALUOp, MADD_EN);

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_BUSY;
          cnt_d   = use_div ? DIV_CNT : MULT_CNT;
          phi_d   = res_hi;
          plo_d   = res_lo;
        end else if (!IntReq && (XALUOp == OP_MTHI)) begin
          hi_d = A;
        end else if (!IntReq && (XALUOp == OP_MTLO)) begin
          lo_d = A;
        end
      end
      ST_BUSY: begin
        // IntReq and Start are deliberately ignored here: an in-flight op
        // always runs to completion. cnt_q==1 is the final Busy cycle.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = phi_q;
          lo_d    = plo_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  always_comb begin
    Busy   = (state_q == ST_BUSY);
    StallX = Start && !IntReq;
    HI     = hi_q;
    LO     = lo_q;
    case (XALUOp)
      OP_MFHI: Out = hi_q;
      OP_MFLO: Out = lo_q;
      default: Out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed table-driven bench for muldiv_unit plus hand-written
//   sequences for IntReq, Start-while-busy, reset-in-flight, mthi/mfhi and madd.
// Inputs are driven on the falling edge and outputs sampled there as well.
import muldiv_pkg::*;

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  XALUOp;
  logic        Start, IntReq;
  logic        Busy, StallX;
  logic [31:0] HI, LO, Out;

  int n_cmp  = 0;
  int n_fail = 0;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .XALUOp(XALUOp), .Start(Start),
    .IntReq(IntReq), .Busy(Busy), .StallX(StallX), .HI(HI), .LO(LO), .Out(Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Launch one op, then count Busy cycles (bounded) and check the commit.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    XALUOp = op; A = a; B = b; Start = 1'b1; IntReq = 1'b0;
    @(negedge clk);
    XALUOp = OP_NONE; Start = 1'b0; A = '0; B = '0;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({name, " busy_len"}, n, exp_busy);
    chk({name, " HI"}, HI, exp_hi);
    chk({name, " LO"}, LO, exp_lo);
  endtask

  initial begin
    int n;

    tbl[0] = '{"mult -2*3",     OP_MULT,  32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[1] = '{"multu fffffffe*3", OP_MULTU, 32'hFFFF_FFFE, 32'd3,      5,  32'h0000_0002, 32'hFFFF_FFFA};
    tbl[2] = '{"mult min*min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};
    tbl[3] = '{"multu max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
    tbl[4] = '{"divu 100/7",    OP_DIVU,  32'd100,       32'd7,         10, 32'd2,         32'd14};
    tbl[5] = '{"div -7/2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[6] = '{"div 7/-2",      OP_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD};
    tbl[7] = '{"divu max/16",   OP_DIVU,  32'hFFFF_FFFF, 32'd16,        10, 32'd15,        32'h0FFF_FFFF};
    tbl[8] = '{"div 5/0",       OP_DIV,   32'd5,         32'd0,         10, 32'd5,         32'hFFFF_FFFF};

    reset = 1'b1; A = '0; B = '0; XALUOp = OP_NONE; Start = 1'b0; IntReq = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset Busy", {31'd0, Busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);

    for (int i = 0; i < 9; i++)
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].busy, tbl[i].hi, tbl[i].lo);

    // Start with IntReq: flushed, no launch; mthi under IntReq also dropped.
    @(negedge clk);
    XALUOp = OP_MULT; A = 32'd7; B = 32'd9; Start = 1'b1; IntReq = 1'b1;
    #1 chk("intreq StallX", {31'd0, StallX}, 32'd0);
    @(negedge clk);
    XALUOp = OP_MTHI; A = 32'hDEAD_BEEF; Start = 1'b0; IntReq = 1'b1;
    chk("intreq Busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    XALUOp = OP_NONE; A = '0; IntReq = 1'b0;
    chk("intreq HI", HI, tbl[8].hi);
    chk("intreq LO", LO, tbl[8].lo);
    @(negedge clk);
    chk("intreq Busy later", {31'd0, Busy}, 32'd0);

    // divu launch, then Start while busy (ignored) and IntReq mid-flight.
    XALUOp = OP_DIVU; A = 32'd100; B = 32'd7; Start = 1'b1;
    #1 chk("launch StallX", {31'd0, StallX}, 32'd1);
    @(negedge clk);                                   // Busy cycle 1
    XALUOp = OP_MULT; A = 32'd3; B = 32'd3; Start = 1'b1;
    @(negedge clk);                                   // Busy cycle 2
    XALUOp = OP_NONE; A = '0; B = '0; Start = 1'b0; IntReq = 1'b1;
    @(negedge clk);                                   // Busy cycle 3
    IntReq = 1'b0;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("midbusy busy_len", n + 2, 32'd10);
    chk("midbusy HI", HI, 32'd2);
    chk("midbusy LO", LO, 32'd14);

    // mthi / mfhi / mflo / Out default.
    XALUOp = OP_MTHI; A = 32'h0000_1234;
    @(negedge clk);
    XALUOp = OP_MFHI; A = '0;
    #1 chk("mthi HI", HI, 32'h0000_1234);
    chk("mfhi Out", Out, 32'h0000_1234);
    chk("mthi Busy", {31'd0, Busy}, 32'd0);
    XALUOp = OP_MFLO;
    #1 chk("mflo Out", Out, 32'd14);
    XALUOp = OP_NONE;
    #1 chk("none Out", Out, 32'd0);

    // Reset at Busy cycle 3 of a mult discards the pending result.
    @(negedge clk);
    XALUOp = OP_MULT; A = 32'd5; B = 32'd5; Start = 1'b1;
    @(negedge clk);                                   // Busy cycle 1
    XALUOp = OP_NONE; A = '0; B = '0; Start = 1'b0;
    @(negedge clk);                                   // Busy cycle 2
    @(negedge clk);                                   // Busy cycle 3
    chk("pre-reset Busy", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("inflight reset Busy", {31'd0, Busy}, 32'd0);
    chk("inflight reset HI", HI, 32'd0);
    chk("inflight reset LO", LO, 32'd0);
    repeat (4) @(negedge clk);
    chk("post-reset Busy", {31'd0, Busy}, 32'd0);
    chk("post-reset LO", LO, 32'd0);

    // madd family: HI=0, LO=ffffffff then maddu 1*1.
    XALUOp = OP_MTHI; A = 32'd0;
    @(negedge clk);
    XALUOp = OP_MTLO; A = 32'hFFFF_FFFF;
    @(negedge clk);
    XALUOp = OP_NONE; A = '0;
`ifdef MULDIV_MADD_EN
    run_op("maddu", OP_MADDU, 32'd1, 32'd1, 5, 32'd1, 32'd0);
    run_op("msub", OP_MSUB, 32'hFFFF_FFFF, 32'd1, 5, 32'd1, 32'd1);
`else
    run_op("maddu off", OP_MADDU, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF);
    run_op("msub off", OP_MSUB, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 32'hFFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
